// File: rtl/oled_pkg.sv
// Shared definitions for the OLED IIC write path: phase encodings,
// IIC device/control bytes and small helper functions.
package oled_pkg;

   // Sequencer phase encoding (3 bits, also exported as the debug phase output)
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INIT  = 3'd1,
      ST_CLEAR = 3'd2,
      ST_FONT  = 3'd3,
      ST_WAIT  = 3'd4,
      ST_NUM   = 3'd5,
      ST_ERROR = 3'd6
   } phase_e;

   // IIC framing bytes shared by every phase generator
   localparam logic [7:0] IIC_DEV_ADDR = 8'h78;
   localparam logic [7:0] CTRL_CMD     = 8'h00;
   localparam logic [7:0] CTRL_DAT     = 8'h40;

   // Width of a counter that must reach max(a,b)-1; never narrower than 1 bit
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

   // Phases that own the IIC writer
   function automatic logic is_active(input phase_e s);
      return (s == ST_INIT) || (s == ST_CLEAR) || (s == ST_FONT) || (s == ST_NUM);
   endfunction

endpackage

// File: rtl/oled_tick_counter.sv
// Shared clear/enable/terminal-count counter. Used as the refresh timer while
// waiting and as the write_done watchdog while a phase is active. Saturates at
// all-ones instead of wrapping.
module oled_tick_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] term_i,
   output logic             tc_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   // Next count: clear has priority, then saturating increment when enabled
   always_comb begin
      // NOTE: assign a default first so every path drives cnt_d and no latch is inferred.
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register with synchronous reset
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignment so every register samples pre-edge values.
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/oled_phase_sequencer.sv
// Top-level scheduler for the OLED IIC write path. Steps INIT -> CLEAR -> FONT,
// then refreshes NUM periodically. Hands the single IIC byte writer to the
// active phase generator: muxes its word out and gates write_done back to it.
module oled_phase_sequencer
   import oled_pkg::*;
#(
   parameter int unsigned REFRESH_CYCLES = 50_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic        start,
   input  logic [23:0] init_data,
   input  logic [23:0] clear_data,
   input  logic [23:0] font_data,
   input  logic [23:0] num_data,
   input  logic        init_fin,
   input  logic        clear_fin,
   input  logic        font_fin,
   input  logic        num_fin,
   output logic        init_req,
   output logic        clear_req,
   output logic        font_req,
   output logic        num_req,
   output logic        init_done,
   output logic        clear_done,
   output logic        font_done,
   output logic        num_done,
   output logic        iic_req,
   output logic [23:0] iic_data,
   input  logic        write_done,
   output logic        busy,
   output logic        err,
   output logic [2:0]  phase
);

   localparam int unsigned      CNT_W      = cnt_width(REFRESH_CYCLES, TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] REFRESH_TC = CNT_W'(REFRESH_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT_CYCLES - 1);

   phase_e           state_q, state_d;
   logic             init_req_q, clear_req_q, font_req_q, num_req_q;
   logic             iic_req_q, busy_q, err_q;
   logic             active;
   logic             cnt_tc, cnt_clr, cnt_en, wd_expire;
   logic [CNT_W-1:0] cnt_term;

   assign active    = is_active(state_q);
   // A write_done in the terminal cycle rescues the phase from the watchdog
   assign wd_expire = cnt_tc & ~write_done;

   // Next-state logic: only the active phase's fin is honoured, and fin beats expiry
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_ERROR: if (start) state_d = ST_INIT;
         ST_INIT: begin
            if (init_fin)       state_d = ST_CLEAR;
            else if (wd_expire) state_d = ST_ERROR;
         end
         ST_CLEAR: begin
            if (clear_fin)      state_d = ST_FONT;
            else if (wd_expire) state_d = ST_ERROR;
         end
         ST_FONT: begin
            if (font_fin)       state_d = ST_WAIT;
            else if (wd_expire) state_d = ST_ERROR;
         end
         ST_NUM: begin
            if (num_fin)        state_d = ST_WAIT;
            else if (wd_expire) state_d = ST_ERROR;
         end
         ST_WAIT: if (cnt_tc) state_d = ST_NUM;
         default: state_d = ST_IDLE;
      endcase
   end

   // Counter restarts on every state change and on each accepted write_done
   assign cnt_clr  = (state_d != state_q) | (active & write_done);
   assign cnt_en   = active | (state_q == ST_WAIT);
   assign cnt_term = (state_q == ST_WAIT) ? REFRESH_TC : TIMEOUT_TC;

   oled_tick_counter #(
      .WIDTH (CNT_W)
   ) u_tick_counter (
      .clk_i  (sys_clk),
      .rst_i  (rst),
      .clr_i  (cnt_clr),
      .en_i   (cnt_en),
      .term_i (cnt_term),
      .tc_o   (cnt_tc)
   );

   // State register plus outputs registered from the next state so they track state exactly
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         init_req_q  <= 1'b0;
         clear_req_q <= 1'b0;
         font_req_q  <= 1'b0;
         num_req_q   <= 1'b0;
         iic_req_q   <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_req_q  <= (state_d == ST_INIT);
         clear_req_q <= (state_d == ST_CLEAR);
         font_req_q  <= (state_d == ST_FONT);
         num_req_q   <= (state_d == ST_NUM);
         iic_req_q   <= is_active(state_d);
         busy_q      <= (state_d != ST_IDLE) && (state_d != ST_ERROR);
         err_q       <= (state_d == ST_ERROR);
      end
   end

   // Word mux: the active generator's word, zero when no phase owns the writer
   always_comb begin
      iic_data = 24'h0;
      case (state_q)
         ST_INIT:  iic_data = init_data;
         ST_CLEAR: iic_data = clear_data;
         ST_FONT:  iic_data = font_data;
         ST_NUM:   iic_data = num_data;
         default:  iic_data = 24'h0;
      endcase
   end

   assign init_done  = write_done & (state_q == ST_INIT);
   assign clear_done = write_done & (state_q == ST_CLEAR);
   assign font_done  = write_done & (state_q == ST_FONT);
   assign num_done   = write_done & (state_q == ST_NUM);

   assign init_req   = init_req_q;
   assign clear_req  = clear_req_q;
   assign font_req   = font_req_q;
   assign num_req    = num_req_q;
   assign iic_req    = iic_req_q;
   assign busy       = busy_q;
   assign err        = err_q;
   assign phase      = state_q;

endmodule
